// File: rtl/demux_pkg.sv
// Shared types, default constants and the word-ratio helper for the lane demux.
package demux_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_STREAM = 2'd2
   } demux_state_t;

   localparam int DEMUX_LANES    = 4;
   localparam int DEMUX_LANE_W   = 8;
   localparam int DEMUX_IN_W     = 16;
   localparam int DEMUX_HOLD_CYC = 8;

   function automatic int demux_ratio(input int lanes,
                                      input int lane_w,
                                      input int in_w);
      return (lanes * lane_w) / in_w;
   endfunction

endpackage

// File: rtl/demux_gap_timer.sv
// Counts consecutive invalid cycles; expire fires combinationally on the
// HOLD_CYC-th one so the caller can act on that same edge.
module demux_gap_timer #(
   parameter int HOLD_CYC = 8
) (
   input  logic clk_2f,
   input  logic reset,
   input  logic valid_in,
   input  logic clear,
   output logic expire
);

   localparam int CW = $clog2(HOLD_CYC + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expire = !valid_in && !clear
                && (cnt_q == CW'(HOLD_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (valid_in || clear || expire) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/demux_lanes_param.sv
// Gathers R input words into one group and presents it on LANES lanes.
// Optional parity output is enabled with DEMUX_LANE_PARITY_EN.
module demux_lanes_param
   import demux_pkg::*;
#(
   parameter int LANES    = DEMUX_LANES,
   parameter int LANE_W   = DEMUX_LANE_W,
   parameter int IN_W     = DEMUX_IN_W,
   parameter int HOLD_CYC = DEMUX_HOLD_CYC
) (
   input  logic                    clk_2f,
   input  logic                    reset,
   input  logic [IN_W-1:0]         data_in,
   input  logic                    valid_in,
   input  logic [LANES-1:0]        lane_en,
   output logic [LANES*LANE_W-1:0] data_out,
   output logic [LANES-1:0]        valid_out,
   output logic                    group_done,
`ifdef DEMUX_LANE_PARITY_EN
   output logic [LANES-1:0]        parity_out,
`endif
   output logic                    frame_err
);

   localparam int R  = demux_ratio(LANES, LANE_W, IN_W);
   localparam int FW = (R > 1) ? $clog2(R) : 1;
   localparam int BW = LANES * LANE_W;

   demux_state_t state_q, state_d;

   logic [FW-1:0]    fill_q, fill_d;
   logic [BW-1:0]    buf_q, buf_d;
   logic [BW-1:0]    dout_q, dout_d;
   logic [LANES-1:0] vout_q, vout_d;
   logic             gd_q, gd_d;
   logic             fe_q, fe_d;
   logic [BW-1:0]    full;
   logic [BW-1:0]    masked;
   logic             last;
   logic             expire;
   logic             t_clear;

   assign t_clear = (state_q == S_IDLE);
   assign last    = (fill_q == FW'(R - 1));

   demux_gap_timer #(
      .HOLD_CYC (HOLD_CYC)
   ) u_gap (
      .clk_2f   (clk_2f),
      .reset    (reset),
      .valid_in (valid_in),
      .clear    (t_clear),
      .expire   (expire)
   );

   // Buffer with the incoming word already placed in its slot
   always_comb begin
      full = buf_q;
      full[int'(fill_q)*IN_W +: IN_W] = data_in;
      masked = '0;
      for (int k = 0; k < LANES; k++) begin
         if (lane_en[k]) begin
            masked[k*LANE_W +: LANE_W] = full[k*LANE_W +: LANE_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      buf_d   = buf_q;
      dout_d  = dout_q;
      vout_d  = vout_q;
      gd_d    = 1'b0;
      fe_d    = 1'b0;
      if (valid_in) begin
         buf_d = full;
         if (last) begin
            fill_d  = '0;
            dout_d  = masked;
            vout_d  = lane_en;
            gd_d    = 1'b1;
            state_d = S_STREAM;
         end else begin
            fill_d = fill_q + FW'(1);
            unique case (state_q)
               S_IDLE:   state_d = S_FILL;
               S_FILL:   state_d = S_FILL;
               S_STREAM: state_d = S_STREAM;
               default:  state_d = S_IDLE;
            endcase
         end
      end else if (expire) begin
         vout_d  = '0;
         fill_d  = '0;
         fe_d    = (fill_q != '0);
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state_q <= S_IDLE;
         fill_q  <= '0;
         buf_q   <= '0;
         dout_q  <= '0;
         vout_q  <= '0;
         gd_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         buf_q   <= buf_d;
         dout_q  <= dout_d;
         vout_q  <= vout_d;
         gd_q    <= gd_d;
         fe_q    <= fe_d;
      end
   end

   assign data_out   = dout_q;
   assign valid_out  = vout_q;
   assign group_done = gd_q;
   assign frame_err  = fe_q;

`ifdef DEMUX_LANE_PARITY_EN
   logic [LANES-1:0] par_q;
   logic [LANES-1:0] par_d;

   always_comb begin
      par_d = par_q;
      if (valid_in && last) begin
         for (int k = 0; k < LANES; k++) begin
            par_d[k] = ^masked[k*LANE_W +: LANE_W];
         end
      end
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         par_q <= '0;
      end else begin
         par_q <= par_d;
      end
   end

   assign parity_out = par_q;
`endif

endmodule

// File: tb/tb_demux_lanes_param.sv
// Directed cycle table plus a few hand-written sequences for demux_lanes_param.
module tb_demux_lanes_param;

   logic        clk_2f = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] data_in = 16'hFFFF;
   logic        valid_in = 1'b1;
   logic [3:0]  lane_en = 4'hF;
   logic [31:0] data_out;
   logic [3:0]  valid_out;
   logic        group_done;
   logic        frame_err;
`ifdef DEMUX_LANE_PARITY_EN
   logic [3:0]  parity_out;
`endif

   demux_lanes_param dut (
      .clk_2f     (clk_2f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .lane_en    (lane_en),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .group_done (group_done),
`ifdef DEMUX_LANE_PARITY_EN
      .parity_out (parity_out),
`endif
      .frame_err  (frame_err)
   );

   always #5 clk_2f = ~clk_2f;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [15:0] din;
      logic [3:0]  en;
      logic [31:0] e_dout;
      logic [3:0]  e_vout;
      logic        e_gd;
      logic        e_fe;
   } vec_t;

   vec_t tbl[$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic add(input logic rst, input logic vld,
                      input logic [15:0] din, input logic [3:0] en,
                      input logic [31:0] ed, input logic [3:0] ev,
                      input logic eg, input logic ef, input int rep);
      vec_t v;
      v.rst = rst; v.vld = vld; v.din = din; v.en = en;
      v.e_dout = ed; v.e_vout = ev; v.e_gd = eg; v.e_fe = ef;
      for (int i = 0; i < rep; i++) tbl.push_back(v);
   endtask

   function automatic logic [3:0] par_of(input logic [31:0] d);
      logic [3:0] p;
      for (int k = 0; k < 4; k++) p[k] = ^d[k*8 +: 8];
      return p;
   endfunction

   task automatic check(input string nm, input logic [31:0] ed,
                        input logic [3:0] ev, input logic eg,
                        input logic ef);
      logic ok;
      ok = (data_out === ed) && (valid_out === ev)
        && (group_done === eg) && (frame_err === ef);
`ifdef DEMUX_LANE_PARITY_EN
      ok = ok && (parity_out === par_of(ed));
`endif
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got d=%h v=%b gd=%b fe=%b want d=%h v=%b gd=%b fe=%b",
                    nm, data_out, valid_out, group_done, frame_err,
                    ed, ev, eg, ef);
   endtask

   task automatic step(input logic rst, input logic vld,
                       input logic [15:0] din, input logic [3:0] en);
      reset = rst; valid_in = vld; data_in = din; lane_en = en;
      @(posedge clk_2f);
      #1;
   endtask

   initial begin
      // reset dominance with valid data present
      add(1, 1, 16'hFFFF, 4'hF, 32'h0, 4'h0, 0, 0, 2);
      // back-to-back group
      add(0, 1, 16'h2211, 4'hF, 32'h0, 4'h0, 0, 0, 1);
      add(0, 1, 16'h4433, 4'hF, 32'h44332211, 4'hF, 1, 0, 1);
      add(0, 0, 16'h0000, 4'hF, 32'h44332211, 4'hF, 0, 0, 1);
      // gap inside a group, then idle after 8 invalid cycles
      add(0, 1, 16'h2211, 4'hF, 32'h44332211, 4'hF, 0, 0, 1);
      add(0, 0, 16'h0000, 4'hF, 32'h44332211, 4'hF, 0, 0, 3);
      add(0, 1, 16'h4433, 4'hF, 32'h44332211, 4'hF, 1, 0, 1);
      add(0, 0, 16'h0000, 4'hF, 32'h44332211, 4'hF, 0, 0, 7);
      add(0, 0, 16'h0000, 4'hF, 32'h44332211, 4'h0, 0, 0, 1);
      // partial group discarded from STREAM
      add(0, 1, 16'h6655, 4'hF, 32'h44332211, 4'h0, 0, 0, 1);
      add(0, 1, 16'h8877, 4'hF, 32'h88776655, 4'hF, 1, 0, 1);
      add(0, 1, 16'hAAAA, 4'hF, 32'h88776655, 4'hF, 0, 0, 1);
      add(0, 0, 16'h0000, 4'hF, 32'h88776655, 4'hF, 0, 0, 7);
      add(0, 0, 16'h0000, 4'hF, 32'h88776655, 4'h0, 0, 1, 1);
      add(0, 1, 16'h2211, 4'hF, 32'h88776655, 4'h0, 0, 0, 1);
      add(0, 1, 16'h4433, 4'hF, 32'h44332211, 4'hF, 1, 0, 1);
      // lane mask, and a mask change mid-group
      add(0, 1, 16'h2211, 4'h5, 32'h44332211, 4'hF, 0, 0, 1);
      add(0, 1, 16'h4433, 4'h5, 32'h00330011, 4'h5, 1, 0, 1);
      add(0, 1, 16'hBEEF, 4'h0, 32'h00330011, 4'h5, 0, 0, 1);
      add(0, 1, 16'hCAFE, 4'hF, 32'hCAFEBEEF, 4'hF, 1, 0, 1);
      // reset mid-group drops it silently
      add(0, 1, 16'h1234, 4'hF, 32'hCAFEBEEF, 4'hF, 0, 0, 1);
      add(1, 0, 16'h0000, 4'hF, 32'h0, 4'h0, 0, 0, 1);
      add(0, 1, 16'hBBAA, 4'hF, 32'h0, 4'h0, 0, 0, 1);
      add(0, 1, 16'hDDCC, 4'hF, 32'hDDCCBBAA, 4'hF, 1, 0, 1);
      // expiry in FILL state
      add(0, 0, 16'h0000, 4'hF, 32'hDDCCBBAA, 4'hF, 0, 0, 7);
      add(0, 0, 16'h0000, 4'hF, 32'hDDCCBBAA, 4'h0, 0, 0, 1);
      add(0, 1, 16'h1111, 4'hF, 32'hDDCCBBAA, 4'h0, 0, 0, 1);
      add(0, 0, 16'h0000, 4'hF, 32'hDDCCBBAA, 4'h0, 0, 0, 7);
      add(0, 0, 16'h0000, 4'hF, 32'hDDCCBBAA, 4'h0, 0, 1, 1);
      add(0, 1, 16'h2222, 4'hF, 32'hDDCCBBAA, 4'h0, 0, 0, 1);
      add(0, 1, 16'h3333, 4'hF, 32'h33332222, 4'hF, 1, 0, 1);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].en);
         check($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_vout,
               tbl[i].e_gd, tbl[i].e_fe);
      end

      // reset wins over a completing word
      step(0, 1, 16'h5544, 4'hF);
      check("pre_rst", 32'h33332222, 4'hF, 0, 0);
      step(1, 1, 16'h7766, 4'hF);
      check("rst_dom", 32'h0, 4'h0, 0, 0);

      // bounded wait for group_done after two words
      begin
         int cyc;
         step(0, 1, 16'h0F0F, 4'hF);
         step(0, 1, 16'h0101, 4'hF);
         reset = 0; valid_in = 0;
         cyc = 0;
         while (!group_done && cyc < 5) begin
            @(posedge clk_2f); #1;
            cyc++;
         end
         check("gd_wait", 32'h01010F0F, 4'hF, 1, 0);
         step(0, 0, 16'h0000, 4'hF);
         check("gd_pulse", 32'h01010F0F, 4'hF, 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/demux_lanes_param.md
Name: demux_lanes_param

Overview:
- Parametrised successor to the fixed 16-to-4x8 lane demux in phy_rx.
- Gathers R = LANES*LANE_W/IN_W consecutive valid input words into one group, then presents that group on LANES parallel output lanes, each with its own valid.
- New over the previous generation: gap tolerance with a programmable hold window, partial-group discard with an error pulse, per-lane enable mask, and a group-complete strobe.
- Sits between the lane-level demux stage and the byte-striping/unstriping logic of phy_rx.

Parameters:
- LANES, 4, number of output lanes (>=2).
- LANE_W, 8, bits per output lane.
- IN_W, 16, input word width; must divide LANES*LANE_W exactly. Derived localparam R = LANES*LANE_W/IN_W, with R >= 1.
- HOLD_CYC, 8, consecutive invalid input cycles tolerated before the stream is declared idle (>=1).

Ports:
- clk_2f, input, 1, single clock for the whole block; all logic on its rising edge.
- reset, input, 1, synchronous active-high reset.
- data_in, input, IN_W, input word.
- valid_in, input, 1, qualifies data_in.
- lane_en, input, LANES, per-lane enable mask; sampled at group completion.
- data_out, output, LANES*LANE_W, packed lanes; lane k = bits [k*LANE_W +: LANE_W].
- valid_out, output, LANES, per-lane valid.
- group_done, output, 1, one-cycle pulse when a new group is loaded onto data_out.
- frame_err, output, 1, one-cycle pulse when a partial group is discarded.

Behaviour:
- Reset: synchronous, active-high, and dominant over all other inputs. On the edge where reset=1:
  - data_out, valid_out, group_done and frame_err all go to 0.
  - Fill count, hold counter and buffer are cleared; state returns to IDLE.
  - A group in progress is dropped silently, with no frame_err.
- Packing: the i-th accepted word of a group (i = 0..R-1) is written to buffer bits [i*IN_W +: IN_W]. The first-received word therefore lands in the lowest lanes.
- Fill count is $clog2(R) bits wide and wraps to 0 after the R-th word.
- Latency: on the edge accepting the R-th word, the full buffer (including that word) is registered onto data_out with 1 cycle latency.
  - That same edge sets valid_out = lane_en and pulses group_done.
  - Lanes with lane_en[k]=0 output zero data.
- data_out and valid_out hold their values until the next group completes or the stream goes idle.
- State machine: IDLE, FILL, STREAM.
  - IDLE: valid_out=0. valid_in=1 stores word 0 and moves to FILL; with R=1 it loads data_out directly and moves to STREAM.
  - FILL (partial group, no outputs yet):
    - valid_in=1 stores the word; on the R-th word, load outputs and go to STREAM.
    - valid_in=0 increments the hold counter.
  - STREAM (outputs valid; a partial next group may be filling):
    - valid_in=1 stores the word and clears the hold counter.
    - valid_in=0 increments the hold counter.
- Gap rule:
  - Any valid_in=1 clears the hold counter; the fill count is frozen during gaps.
  - When the hold counter reaches HOLD_CYC (on the HOLD_CYC-th consecutive invalid cycle), on that edge:
    - valid_out goes to 0; data_out retains its last value.
    - Fill count clears; state goes to IDLE.
    - frame_err pulses if fill count != 0.
- Simultaneous events:
  - Group completion and hold expiry cannot coincide, because completion requires valid_in=1.
  - A lane_en change mid-group affects only the next group loaded.

Optional Feature:
- Macro: DEMUX_LANE_PARITY_EN.
- Defined: adds output parity_out [LANES], where parity_out[k] is the XOR of lane k data.
  - Registered in the same cycle as data_out.
  - 0 for disabled lanes and on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package demux_pkg holds:
  - the state encoding (IDLE, FILL, STREAM);
  - default constants DEMUX_LANES=4, DEMUX_LANE_W=8, DEMUX_IN_W=16, DEMUX_HOLD_CYC=8;
  - the R derivation helper.
- One sub-module, demux_gap_timer:
  - HOLD_CYC parameter; inputs clk_2f, reset, valid_in, clear; output expire (pulse).
  - Counter width $clog2(HOLD_CYC+1).

Test Plan (defaults LANES=4, LANE_W=8, IN_W=16, HOLD_CYC=8, lane_en=4'hF):
- Reset held 2 cycles with valid_in=1, data_in=16'hFFFF -> data_out=0, valid_out=0, group_done=0, frame_err=0.
- 16'h2211 then 16'h4433 on consecutive cycles -> next cycle data_out=32'h44332211, valid_out=4'hF, group_done high for exactly 1 cycle.
- 16'h2211, 3 invalid cycles, 16'h4433 -> data_out=32'h44332211, no frame_err. 7 further invalid cycles -> valid_out stays 4'hF; 8th invalid cycle -> valid_out=0, frame_err=0.
- From STREAM, 16'hAAAA then 8 invalid cycles -> valid_out=0 and frame_err pulse on the 8th. Then 16'h2211, 16'h4433 -> data_out=32'h44332211, with the partial word discarded.
- lane_en=4'b0101, words 16'h2211, 16'h4433 -> data_out=32'h00330011, valid_out=4'b0101.
- Reset asserted after the first word of a group -> outputs 0 next edge, no frame_err. Then 16'hBBAA, 16'hDDCC -> data_out=32'hDDCCBBAA. With DEMUX_LANE_PARITY_EN defined, parity_out=4'b0000.
